vector_sequencer: RTL and testbench

- Downstream consumer of the vector display-list ROM. Walks the ROM from a base address and turns each entry into beam position and beam enable for the X/Y DAC stage.
- Each ROM word is {x[7:0], y[7:0], line, pos}:
  - pos only = blanked move.
  - line only = visible draw.
  - line+pos, or all-zero = end-of-list marker.
- Draws are slew-limited: x/y step toward the target, so the CRT beam traces the line rather than jumping.

---
 rtl/vector_sequencer.sv | 168 ++++++++++++++++
 tb/tb_vector_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sequencer.sv
// Vector display-list sequencer: walks a combinational ROM from base_addr and
// turns each entry into beam X/Y position and beam enable for the DAC stage.
// ROM word layout is {x[7:0], y[7:0], line, pos}:
//   01 = blanked move, 10 = visible slew-limited draw, 11/00 = end of list.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              run request (level); a frame always runs to its end marker
//   base_addr       first list entry, sampled at start and at every restart
//   rom_addr        address to the ROM; rom_data is its word in the same cycle
//   x_out, y_out    beam position to the DACs
//   beam_on         1 = beam visible
//   busy            1 whenever the sequencer is not idle
//   frame_done      one-cycle pulse on each end-marker decode
module vector_sequencer #(
  parameter int unsigned ADDRESSWIDTH  = 16,
  parameter int unsigned DATAWIDTH     = 18,
  parameter int unsigned STEP          = 1,
  parameter int unsigned TICK_DIV      = 1,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [ADDRESSWIDTH-1:0] base_addr,
  output logic [ADDRESSWIDTH-1:0] rom_addr,
  input  logic [DATAWIDTH-1:0]    rom_data,
  output logic [7:0]              x_out,
  output logic [7:0]              y_out,
  output logic                    beam_on,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, SETTLE, DRAW} state_t;

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [TICK_W-1:0]   tick_cnt;
  logic [7:0]          tx;
  logic [7:0]          ty;

  // ROM word fields
  logic [7:0] w_x;
  logic [7:0] w_y;
  logic [1:0] w_kind;

  assign w_x    = rom_data[17:10];
  assign w_y    = rom_data[9:2];
  assign w_kind = rom_data[1:0];

  // One slew step toward the target; the 9-bit signed difference cannot wrap,
  // and a remaining distance within STEP lands exactly on the target.
  function automatic logic [7:0] slew(input logic [7:0] cur, input logic [7:0] tgt);
    logic signed [8:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > $signed(9'(STEP)))
      slew = cur + 8'(STEP);
    else if (diff < -$signed(9'(STEP)))
      slew = cur - 8'(STEP);
    else
      slew = tgt;
  endfunction

  logic [7:0] next_x_c;
  logic [7:0] next_y_c;
  logic       tick_c;

  // Next slew position and tick strobe for DRAW
  always_comb begin
    next_x_c = slew(x_out, tx);
    next_y_c = slew(y_out, ty);
    tick_c   = (tick_cnt == TICK_W'(TICK_DIV - 1));
  end

  // Sequencer state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      x_out      <= '0;
      y_out      <= '0;
      beam_on    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      settle_cnt <= '0;
      tick_cnt   <= '0;
      tx         <= '0;
      ty         <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          beam_on <= 1'b0;
          if (en) begin
            rom_addr <= base_addr;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end

        FETCH: begin
          case (w_kind)
            2'b01: begin
              x_out   <= w_x;
              y_out   <= w_y;
              beam_on <= 1'b0;
              if (SETTLE_CYCLES > 0) begin
                settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
                state      <= SETTLE;
              end else begin
                rom_addr <= rom_addr + ADDRESSWIDTH'(1);
              end
            end
            2'b10: begin
              tx       <= w_x;
              ty       <= w_y;
              beam_on  <= 1'b1;
              tick_cnt <= '0;
              state    <= DRAW;
            end
            default: begin
              // End marker: restart from a freshly sampled base, or stop
              beam_on    <= 1'b0;
              frame_done <= 1'b1;
              if (en) begin
                rom_addr <= base_addr;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          endcase
        end

        SETTLE: begin
          settle_cnt <= settle_cnt - SETTLE_W'(1);
          if (settle_cnt == SETTLE_W'(1)) begin
            rom_addr <= rom_addr + ADDRESSWIDTH'(1);
            state    <= FETCH;
          end
        end

        DRAW: begin
          if (tick_c) begin
            tick_cnt <= '0;
            x_out    <= next_x_c;
            y_out    <= next_y_c;
            if ((next_x_c == tx) && (next_y_c == ty)) begin
              rom_addr <= rom_addr + ADDRESSWIDTH'(1);
              state    <= FETCH;
            end
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: two instances with different parameter sets share
// stimulus; each is checked every cycle against a list-walking reference model.
module tb_vector_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] base_a;
  logic [3:0]  base_b;
  logic [15:0] addr_a;
  logic [3:0]  addr_b;
  logic [17:0] data_a;
  logic [17:0] data_b;
  logic [7:0]  xa, ya, xb, yb;
  logic        beam_a, busy_a, fd_a;
  logic        beam_b, busy_b, fd_b;

  logic [17:0] rom [2][16];

  int e_addr [2];
  int e_x    [2];
  int e_y    [2];
  int e_beam [2];
  int e_busy [2];
  int e_fd   [2];

  bit running;
  int n_vec;
  int n_err;

  always #5 clk = ~clk;

  assign base_b = base_a[3:0];
  assign data_a = rom[0][addr_a[3:0]];
  assign data_b = rom[1][addr_b];

  vector_sequencer #(
    .ADDRESSWIDTH(16), .DATAWIDTH(18), .STEP(1), .TICK_DIV(1), .SETTLE_CYCLES(2)
  ) u_a (
    .clk(clk), .rst(rst), .en(en), .base_addr(base_a), .rom_addr(addr_a),
    .rom_data(data_a), .x_out(xa), .y_out(ya), .beam_on(beam_a), .busy(busy_a),
    .frame_done(fd_a)
  );

  vector_sequencer #(
    .ADDRESSWIDTH(4), .DATAWIDTH(18), .STEP(4), .TICK_DIV(3), .SETTLE_CYCLES(0)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .base_addr(base_b), .rom_addr(addr_b),
    .rom_data(data_b), .x_out(xb), .y_out(yb), .beam_on(beam_b), .busy(busy_b),
    .frame_done(fd_b)
  );

  task automatic chk(input string tag, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] @%0t got=%0d exp=%0d", tag, k, $time, got, exp);
    end
  endtask

  task automatic check_all(input int k);
    if (k == 0) begin
      chk("rom_addr", 0, 32'(addr_a), 32'(e_addr[0]));
      chk("x_out", 0, 32'(xa), 32'(e_x[0]));
      chk("y_out", 0, 32'(ya), 32'(e_y[0]));
      chk("beam_on", 0, 32'(beam_a), 32'(e_beam[0]));
      chk("busy", 0, 32'(busy_a), 32'(e_busy[0]));
      chk("frame_done", 0, 32'(fd_a), 32'(e_fd[0]));
    end else begin
      chk("rom_addr", 1, 32'(addr_b), 32'(e_addr[1]));
      chk("x_out", 1, 32'(xb), 32'(e_x[1]));
      chk("y_out", 1, 32'(yb), 32'(e_y[1]));
      chk("beam_on", 1, 32'(beam_b), 32'(e_beam[1]));
      chk("busy", 1, 32'(busy_b), 32'(e_busy[1]));
      chk("frame_done", 1, 32'(fd_b), 32'(e_fd[1]));
    end
  endtask

  // One slew step on one axis, straight from the distance rule
  function automatic int slew_ref(input int cur, input int tgt, input int s);
    if (tgt - cur > s) return cur + s;
    if (cur - tgt > s) return cur - s;
    return tgt;
  endfunction

  // Wait for the next clock edge and capture the inputs seen at that edge
  task automatic adv(input int k, output bit alive, output bit en_e, output int b_e);
    @(posedge clk);
    alive   = running;
    en_e    = en;
    b_e     = int'(base_a);
    e_fd[k] = 0;
  endtask

  // Reference model: walks the display list entry by entry, spending the
  // number of clocks each entry costs and publishing the resulting outputs.
  task automatic model(input int k);
    bit          alive;
    bit          en_e;
    bit          in_frame;
    bit          drawing;
    int          b_e;
    int          tx, ty;
    logic [17:0] w;
    int          s  = (k == 0) ? 1 : 4;
    int          td = (k == 0) ? 1 : 3;
    int          st = (k == 0) ? 2 : 0;
    int          am = (k == 0) ? 32'hFFFF : 32'hF;
    forever begin
      do begin
        adv(k, alive, en_e, b_e);
        if (!alive) return;
      end while (!en_e);
      e_addr[k] = b_e & am;
      e_busy[k] = 1;
      in_frame  = 1'b1;
      while (in_frame) begin
        w  = rom[k][e_addr[k] & 15];
        tx = int'(w[17:10]);
        ty = int'(w[9:2]);
        adv(k, alive, en_e, b_e);
        if (!alive) return;
        if (w[1:0] == 2'b01) begin
          e_x[k]    = tx;
          e_y[k]    = ty;
          e_beam[k] = 0;
          if (st == 0) e_addr[k] = (e_addr[k] + 1) & am;
          for (int i = 1; i <= st; i++) begin
            adv(k, alive, en_e, b_e);
            if (!alive) return;
            if (i == st) e_addr[k] = (e_addr[k] + 1) & am;
          end
        end else if (w[1:0] == 2'b10) begin
          e_beam[k] = 1;
          drawing   = 1'b1;
          while (drawing) begin
            for (int i = 0; i < td; i++) begin
              adv(k, alive, en_e, b_e);
              if (!alive) return;
            end
            e_x[k] = slew_ref(e_x[k], tx, s);
            e_y[k] = slew_ref(e_y[k], ty, s);
            if (e_x[k] == tx && e_y[k] == ty) begin
              e_addr[k] = (e_addr[k] + 1) & am;
              drawing   = 1'b0;
            end
          end
        end else begin
          e_beam[k] = 0;
          e_fd[k]   = 1;
          if (en_e) begin
            e_addr[k] = b_e & am;
          end else begin
            e_busy[k] = 0;
            in_frame  = 1'b0;
          end
        end
      end
    end
  endtask

  // Per-cycle checking and en/base stimulus; mode 0 = en held, 1 = en dropped
  // at drop_at, 2 = random en toggles and base changes.
  task automatic drive(input int ncyc, input int mode, input int drop_at);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check_all(0);
      check_all(1);
      if (mode == 1) en = (c < drop_at);
      else if (mode == 2 && $urandom_range(0, 29) == 0) en = ~en;
      if (mode == 2 && $urandom_range(0, 19) == 0) base_a = 16'($urandom);
    end
    running = 1'b0;
    @(posedge clk);
  endtask

  task automatic run_phase(input int ncyc, input int mode, input int drop_at,
                           input logic [15:0] base);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'($urandom);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      e_addr[k] = 0; e_x[k] = 0; e_y[k] = 0;
      e_beam[k] = 0; e_busy[k] = 0; e_fd[k] = 0;
      check_all(k);
    end
    rst     = 1'b0;
    base_a  = base;
    en      = (mode == 2) ? 1'($urandom) : 1'b1;
    running = 1'b1;
    fork
      model(0);
      model(1);
      drive(ncyc, mode, drop_at);
    join
  endtask

  function automatic logic [17:0] rnd_word();
    logic [7:0] x = 8'($urandom);
    logic [7:0] y = 8'($urandom);
    int         r = $urandom_range(0, 9);
    if (r < 4) return {x, y, 2'b01};
    if (r < 8) return {x, y, 2'b10};
    if (r == 8) return {x, y, 2'b11};
    return 18'd0;
  endfunction

  task automatic load_directed();
    for (int i = 0; i < 16; i++) begin
      rom[0][i] = rnd_word();
      rom[1][i] = rnd_word();
    end
    rom[0][0] = {8'd10, 8'd20, 2'b01};
    rom[0][1] = {8'd13, 8'd18, 2'b10};
    rom[0][2] = {8'd0,  8'd0,  2'b11};
    rom[1][0] = {8'd0,  8'd0,  2'b01};
    rom[1][1] = {8'd10, 8'd255, 2'b10};
    rom[1][2] = 18'd0;
  endtask

  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    base_a  = '0;
    running = 1'b0;
    n_vec   = 0;
    n_err   = 0;

    // Basic frame and slew clamp, several frames long
    load_directed();
    run_phase(420, 0, 0, 16'd0);
    // Reset in the middle of the first draw, then a clean restart
    run_phase(6, 0, 0, 16'd0);
    run_phase(40, 0, 0, 16'd0);
    // en dropped during the first draw: frame finishes, then idle
    run_phase(260, 1, 6, 16'd0);

    // Lists of moves only: address wraps with no frame_done
    for (int i = 0; i < 16; i++) begin
      rom[0][i] = {8'($urandom), 8'($urandom), 2'b01};
      rom[1][i] = {8'($urandom), 8'($urandom), 2'b01};
    end
    run_phase(90, 0, 0, 16'd3);

    // Random lists with random en/base activity
    for (int p = 0; p < 24; p++) begin
      for (int i = 0; i < 16; i++) begin
        rom[0][i] = rnd_word();
        rom[1][i] = rnd_word();
      end
      run_phase($urandom_range(150, 500), $urandom_range(0, 2),
                $urandom_range(1, 60), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
